// File: rtl/tx_pkg.sv
// Shared types and default parameters for the transmit filter sequencer.
package tx_pkg;

    localparam int unsigned DW_DEF       = 18;
    localparam int unsigned UPS_DEF      = 4;
    localparam int unsigned NTAPS_DEF    = 21;
    localparam int unsigned FILT_LAT_DEF = 3;

    localparam int unsigned FLUSH_LEN = NTAPS_DEF - 1;
    localparam int unsigned WARM_LEN  = NTAPS_DEF + FILT_LAT_DEF;

    typedef enum logic [2:0] {
        StWarm,
        StIdle,
        StRun,
        StFlush,
        StDrain
    } tx_ctrl_state_t;

endpackage

// File: rtl/tx_tag_pipe.sv
// Delay line for the {valid, last} sample tag, matched to the filter latency.
module tx_tag_pipe
    import tx_pkg::*;
#(
    parameter int unsigned DEPTH = FILT_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic i_last,
    output logic o_valid,
    output logic o_last
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_last  <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_last[0]  <= i_last;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_last[i]  <= r_last[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_last  = r_last[DEPTH-1];

endmodule

// File: rtl/tx_filter_ctrl.sv
// Sample-rate sequencer for the pulse-shaping FIR: zero-stuffs symbols, flushes the
// filter tail after each burst and frames the filter output with valid/last.
module tx_filter_ctrl
    import tx_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned UPS      = UPS_DEF,
    parameter int unsigned NTAPS    = NTAPS_DEF,
    parameter int unsigned FILT_LAT = FILT_LAT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic [DW-1:0] filt_x,
    input  logic [DW-1:0] filt_y,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    output logic          m_last,
    output logic          busy,
    output logic          underrun
);

    localparam int unsigned FlushLen = NTAPS - 1;
    localparam int unsigned WarmLen  = NTAPS + FILT_LAT;
    localparam int unsigned PW       = $clog2(UPS);
    localparam int unsigned CW       = $clog2(WarmLen + 1);
    localparam logic [PW-1:0] PLast  = PW'(UPS - 1);

    tx_ctrl_state_t r_state;
    logic [PW-1:0]  r_p;
    logic [CW-1:0]  r_cnt;
    logic [DW-1:0]  r_filt_x;
    logic           r_last_taken;
    logic           r_underrun;

    logic w_s_ready;
    logic w_hs;
    logic w_tag_valid;
    logic w_tag_last;

    // Symbol slots open in IDLE and on the last phase of a RUN symbol period.
    assign w_s_ready = (r_state == StIdle) ||
                       ((r_state == StRun) && (r_p == PLast) && !r_last_taken);
    assign w_hs      = s_valid && w_s_ready;

    // Tag describes the sample currently on filt_x.
    assign w_tag_valid = (r_state == StRun) || (r_state == StFlush);
    assign w_tag_last  = (r_state == StFlush) && (r_cnt == '0);

    // r_cnt holds remaining cycles minus one, so each phase ends when it reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StWarm;
            r_cnt        <= CW'(WarmLen - 1);
            r_p          <= '0;
            r_filt_x     <= '0;
            r_last_taken <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            case (r_state)
                StWarm: begin
                    r_filt_x <= '0;
                    if (r_cnt == '0) begin
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StIdle: begin
                    if (w_hs) begin
                        r_filt_x     <= s_data;
                        r_p          <= '0;
                        r_last_taken <= s_last;
                        r_underrun   <= 1'b0;
                        r_state      <= StRun;
                    end else begin
                        r_filt_x <= '0;
                    end
                end
                StRun: begin
                    if (r_p != PLast) begin
                        r_filt_x <= '0;
                        r_p      <= r_p + 1'b1;
                    end else if (r_last_taken) begin
                        r_filt_x <= '0;
                        r_cnt    <= CW'(FlushLen - 1);
                        r_state  <= StFlush;
                    end else if (s_valid) begin
                        r_filt_x     <= s_data;
                        r_p          <= '0;
                        r_last_taken <= s_last;
                    end else begin
                        // Missed slot: emit a zero and keep the symbol grid.
                        r_filt_x   <= '0;
                        r_p        <= '0;
                        r_underrun <= 1'b1;
                    end
                end
                StFlush: begin
                    r_filt_x <= '0;
                    if (r_cnt == '0) begin
                        r_cnt   <= CW'(FILT_LAT - 1);
                        r_state <= StDrain;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StDrain: begin
                    r_filt_x <= '0;
                    if (r_cnt == '0) begin
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_filt_x <= '0;
                    r_cnt    <= CW'(WarmLen - 1);
                    r_state  <= StWarm;
                end
            endcase
        end
    end

    tx_tag_pipe #(
        .DEPTH(FILT_LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .i_valid(w_tag_valid),
        .i_last (w_tag_last),
        .o_valid(m_valid),
        .o_last (m_last)
    );

    assign s_ready  = w_s_ready;
    assign filt_x   = r_filt_x;
    assign m_data   = filt_y;
    assign busy     = (r_state != StIdle);
    assign underrun = r_underrun;

endmodule

// File: tb/tb_tx_filter_ctrl.sv
// Scoreboard bench for tx_filter_ctrl with a behavioural 21-tap, 3-cycle FIR attached.
module tb_tx_filter_ctrl;

    localparam int DW    = 18;
    localparam int NTAPS = 21;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [DW-1:0] filt_x;
    logic [DW-1:0] filt_y;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          busy;
    logic          underrun;

    always #5 clk = ~clk;

    tx_filter_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .filt_x  (filt_x),
        .filt_y  (filt_y),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .busy    (busy),
        .underrun(underrun)
    );

    // Symmetric taps in 1s17, peak at index 10.
    function automatic int tap(int k);
        return (k <= 10) ? (k + 1) * 1000 : (21 - k) * 1000;
    endfunction

    // Filter model: filt_x at cycle c appears on filt_y at c+3.
    logic signed [DW-1:0] x_hist [0:19] = '{default: '0};
    logic signed [DW-1:0] y1 = '0;
    logic signed [DW-1:0] y2 = '0;
    logic signed [DW-1:0] y3 = '0;
    assign filt_y = y3;

    always @(posedge clk) begin
        longint acc;
        acc = longint'(tap(0)) * longint'($signed(filt_x));
        for (int k = 1; k < NTAPS; k++) acc += longint'(tap(k)) * longint'(x_hist[k-1]);
        for (int k = 19; k > 0; k--) x_hist[k] <= x_hist[k-1];
        x_hist[0] <= $signed(filt_x);
        y1 <= DW'(acc >>> 17);
        y2 <= y1;
        y3 <= y2;
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int zero_err = 0;
    int mv_cnt = 0;
    int ml_cnt = 0;
    int ml_cyc = 0;
    logic prev_mv = 1'b0;

    typedef struct {
        int   data;
        logic last;
        logic first;
    } exp_t;
    exp_t sb[$];
    int seq_buf [0:63];

    function automatic void chk(string name, longint act, longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expectation per presented output sample.
    always @(negedge clk) begin
        if (m_valid) begin
            mv_cnt++;
            if (m_last) begin
                ml_cnt++;
                ml_cyc = cyc;
            end
            if (sb.size() == 0) begin
                chk("unexpected_m_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("m_data", $signed(m_data), e.data);
                chk("m_last", m_last, e.last);
                if (e.first) chk("burst_separated", prev_mv, 0);
                else         chk("burst_contiguous", prev_mv, 1);
            end
        end
        prev_mv = m_valid;
    end

    function automatic int conv(int i);
        longint acc = 0;
        for (int k = 0; k < NTAPS; k++)
            if (i - k >= 0) acc += longint'(tap(k)) * longint'(seq_buf[i-k]);
        return int'(acc >>> 17);
    endfunction

    task automatic clear_seq();
        foreach (seq_buf[i]) seq_buf[i] = 0;
    endtask

    task automatic push_conv(input int len);
        for (int i = 0; i < len; i++) begin
            exp_t e;
            e.data  = conv(i);
            e.last  = (i == len - 1);
            e.first = (i == 0);
            sb.push_back(e);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
            if (filt_x != '0) zero_err++;
        end
        if (!s_ready) chk("s_ready_timeout", 0, 1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
            if (filt_x != '0) zero_err++;
        end
        if (busy) chk("idle_timeout", 0, 1);
    endtask

    // Presents one symbol, returns wait cycles and the handshake cycle.
    task automatic send(input int d, input logic l, output int n, output int hs);
        s_data  = DW'(d);
        s_last  = l;
        s_valid = 1'b1;
        wait_ready(n);
        hs = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("filt_x_symbol", $signed(filt_x), d);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, hs, hs1, hs2, miss, mv0, ml0, warm_err;

        // Reset values and warm-up with s_valid held high.
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_filt_x", filt_x, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 1);
        chk("rst_underrun", underrun, 0);

        for (int i = 0; i < 24; i++) begin
            exp_t e;
            e.data  = (i < 21) ? tap(i) - 1 : 0;
            e.last  = (i == 23);
            e.first = (i == 0);
            sb.push_back(e);
        end
        s_data  = DW'(131071);
        s_last  = 1'b1;
        s_valid = 1'b1;
        reset   = 1'b0;
        n = 0;
        warm_err = 0;
        while (!s_ready && n < 100) begin
            if (!busy || m_valid || filt_x != '0) warm_err++;
            @(negedge clk);
            n++;
        end
        chk("warm_len", n, 24);
        chk("warm_flags", warm_err, 0);
        chk("idle_busy", busy, 0);
        hs = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("impulse_filt_x", $signed(filt_x), 131071);

        // Single-symbol impulse framing.
        wait_idle(n);
        chk("impulse_m_valid_count", mv_cnt, 24);
        chk("impulse_m_last_time", ml_cyc - hs, 27);
        chk("impulse_idle_after_last", cyc - ml_cyc, 1);
        chk("impulse_idle_after_flush", cyc - (hs + 24), 4);
        chk("impulse_sb_empty", sb.size(), 0);

        // Gapless three-symbol burst.
        mv0 = mv_cnt;
        clear_seq();
        seq_buf[0] = 65536;
        seq_buf[4] = -65536;
        seq_buf[8] = 65536;
        push_conv(32);
        send(65536, 1'b0, n, hs);
        send(-65536, 1'b0, n, hs1);
        chk("gapless_slot1", hs1 - hs, 4);
        send(65536, 1'b1, n, hs2);
        chk("gapless_slot2", hs2 - hs1, 4);
        wait_idle(n);
        chk("gapless_m_valid_count", mv_cnt - mv0, 32);
        chk("gapless_underrun", underrun, 0);
        chk("gapless_sb_empty", sb.size(), 0);

        // Underrun at the second slot.
        mv0 = mv_cnt;
        clear_seq();
        seq_buf[0]  = 65536;
        seq_buf[8]  = -65536;
        seq_buf[12] = 65536;
        push_conv(36);
        send(65536, 1'b0, n, hs);
        wait_ready(n);
        miss = cyc;
        chk("underrun_slot_time", miss - hs, 4);
        @(negedge clk);
        chk("underrun_slot_filt_x", filt_x, 0);
        chk("underrun_flag", underrun, 1);
        send(-65536, 1'b0, n, hs1);
        chk("underrun_grid", hs1 - miss, 4);
        send(65536, 1'b1, n, hs2);
        wait_idle(n);
        chk("underrun_m_valid_count", mv_cnt - mv0, 36);
        chk("underrun_sticky", underrun, 1);
        chk("underrun_sb_empty", sb.size(), 0);

        // Back-to-back bursts, second offered during DRAIN.
        mv0 = mv_cnt;
        ml0 = ml_cnt;
        clear_seq();
        seq_buf[0] = 65536;
        push_conv(24);
        send(65536, 1'b1, n, hs);
        chk("underrun_cleared", underrun, 0);
        repeat (24) @(negedge clk);
        chk("drain_busy", busy, 1);
        clear_seq();
        seq_buf[0] = -65536;
        push_conv(24);
        send(-65536, 1'b1, n, hs1);
        chk("drain_wait", n, 3);
        chk("b2b_handshake_gap", hs1 - hs, 28);
        wait_idle(n);
        chk("b2b_m_valid_count", mv_cnt - mv0, 48);
        chk("b2b_m_last_count", ml_cnt - ml0, 2);
        chk("b2b_sb_empty", sb.size(), 0);

        // Reset five cycles into FLUSH.
        ml0 = ml_cnt;
        clear_seq();
        seq_buf[0] = 65536;
        push_conv(24);
        send(65536, 1'b1, n, hs);
        repeat (9) @(negedge clk);
        chk("flush_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_last", m_last, 0);
        chk("midrst_filt_x", filt_x, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_busy", busy, 1);
        sb.delete();
        reset = 1'b0;
        wait_ready(n);
        chk("rewarm_len", n, 24);
        chk("midrst_no_m_last", ml_cnt - ml0, 0);
        chk("filt_x_zero_fill", zero_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
